// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 16:1 mux select across a held word and streams the selected bits; MUX_SCAN_REVERSE_EN scans from LAST_SEL down to channel 0
module mux_scan_sequencer #(
   parameter int LAST_SEL = 15,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [15:0]      mux_data,
   output logic [3:0]       mux_sel,
   input  logic             mux_bit,
   output logic             bit_data,
   output logic             bit_valid,
   output logic             bit_last,
   input  logic             bit_ready,
   output logic [CNT_W-1:0] word_cnt,
   output logic             busy
);
   localparam logic [3:0] LS = 4'(LAST_SEL);
`ifdef MUX_SCAN_REVERSE_EN
   localparam logic [3:0] START   = LS;
   localparam logic [3:0] END_SEL = 4'd0;
   localparam logic [3:0] STEP    = 4'hf;
`else
   localparam logic [3:0] START   = 4'd0;
   localparam logic [3:0] END_SEL = LS;
   localparam logic [3:0] STEP    = 4'd1;
`endif
   typedef enum logic {IDLE, SCAN} state_t;
   state_t state;
   logic   at_end;
   assign at_end    = mux_sel == END_SEL;
   assign busy      = !rst && state == SCAN;
   assign bit_valid = busy;
   assign bit_last  = busy && at_end;
   assign bit_data  = mux_bit;
   assign in_ready  = !rst && (state == IDLE || (bit_last && bit_ready));
   // load a word, step the select on each accepted bit, reload or idle after the last channel
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mux_data <= '0;
         mux_sel  <= START;
         word_cnt <= '0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            mux_data <= in_data;
            mux_sel  <= START;
            state    <= SCAN;
         end
      end else if (bit_ready) begin
         if (!at_end) mux_sel <= mux_sel + STEP;
         else begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (in_valid) begin
               mux_data <= in_data;
               mux_sel  <= START;
            end else state <= IDLE;
         end
      end
   end
endmodule
